// File: rtl/sprite_motion_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_motion_ctrl
//
// Per-frame motion sequencer for the sprite renderers. On every rising edge of
// vsync it walks the sprite slots, one slot per clock. Each slot moves by STEP
// pixels on both axes and bounces off the screen edges. The resulting
// positions feed the renderers' sprite_x / sprite_y inputs.
//
// Optional feature macro: SPRITE_COLLISION_EN
//   defined   - overlapping 'drawing' pulses are latched over the frame. A
//               sprite flagged in 'collided' has both directions reversed
//               before its next step.
//   undefined - no collision logic; 'collided' is tied to 0 and 'drawing' is
//               ignored.
//
// Ports
//   clk          in   pixel clock, rising edge
//   reset        in   synchronous, active-low reset
//   vsync        in   vertical sync (same signal the renderers see)
//   pause        in   high suppresses position updates for that frame
//   drawing      in   [N_SPRITES]     per-slot renderer 'drawing' outputs
//   sprite_x     out  [10*N_SPRITES]  slot i at bits [10i+9:10i]
//   sprite_y     out  [10*N_SPRITES]  same packing as sprite_x
//   busy         out  high during the update sequence (UPDATE + DONE)
//   frame_count  out  [16] completed update sequences, wraps
//   collided     out  [N_SPRITES]     per-slot collision flags, previous frame
// -----------------------------------------------------------------------------
module sprite_motion_ctrl #(
  parameter int N_SPRITES = 4,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int SPRITE_W  = 32,
  parameter int SPRITE_H  = 32,
  parameter int STEP      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    vsync,
  input  logic                    pause,
  input  logic [N_SPRITES-1:0]    drawing,
  output logic [10*N_SPRITES-1:0] sprite_x,
  output logic [10*N_SPRITES-1:0] sprite_y,
  output logic                    busy,
  output logic [15:0]             frame_count,
  output logic [N_SPRITES-1:0]    collided
);

  localparam int X_MAX = H_RES - SPRITE_W;
  localparam int Y_MAX = V_RES - SPRITE_H;
  localparam int IDX_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
  localparam logic [10:0] X_LIM = 11'(X_MAX);
  localparam logic [10:0] Y_LIM = 11'(Y_MAX);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SPRITES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic                vsync_q;
  logic                trigger;
  logic                upd_en;

  logic [9:0]          x_q [N_SPRITES];
  logic [9:0]          y_q [N_SPRITES];
  logic [N_SPRITES-1:0] dx_neg_q;
  logic [N_SPRITES-1:0] dy_neg_q;

  logic [9:0]          rst_x [N_SPRITES];
  logic [9:0]          rst_y [N_SPRITES];
  logic [N_SPRITES-1:0] rst_dx_neg;

  // Slot being updated this cycle and its freshly stepped state.
  logic                flip;
  logic                dx_eff, dy_eff;
  logic [10:0]         x_step, y_step;

  assign trigger = vsync & ~vsync_q;

  // Returns {new_dir_neg, new_pos}. The position is widened to 11 bits so the
  // edge comparisons cannot wrap.
  function automatic logic [10:0] step_axis(input logic [9:0]  pos,
                                            input logic        neg,
                                            input logic [10:0] lim);
    logic [10:0] ext;
    logic [10:0] sum;
    logic [10:0] res;
    ext = {1'b0, pos};
    sum = ext + 11'(STEP);
    if (!neg) begin
      if (sum > lim) res = {1'b1, lim[9:0]};
      else           res = {1'b0, sum[9:0]};
    end else begin
      if (ext < 11'(STEP)) res = {1'b0, 10'd0};
      else                 res = {1'b1, 10'(ext - 11'(STEP))};
    end
    return res;
  endfunction

  // Per-slot reset constants and output packing.
  for (genvar gi = 0; gi < N_SPRITES; gi++) begin : g_slot
    assign rst_x[gi]      = 10'((64 + 128 * gi) % (X_MAX + 1));
    assign rst_y[gi]      = 10'((64 + 64 * gi) % (Y_MAX + 1));
    assign rst_dx_neg[gi] = ((gi % 2) == 1);
    assign sprite_x[10*gi +: 10] = x_q[gi];
    assign sprite_y[10*gi +: 10] = y_q[gi];
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      frame_count_q <= '0;
      vsync_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      frame_count_q <= frame_count_d;
      vsync_q       <= vsync;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    frame_count_d = frame_count_q;
    busy          = 1'b0;
    upd_en        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trigger && !pause) begin
          state_d = S_UPDATE;
          idx_d   = '0;
        end
      end
      S_UPDATE: begin
        busy   = 1'b1;
        upd_en = 1'b1;
        if (idx_q == LAST_IDX) state_d = S_DONE;
        else                   idx_d   = idx_q + 1'b1;
      end
      S_DONE: begin
        busy          = 1'b1;
        frame_count_d = frame_count_q + 16'd1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign frame_count = frame_count_q;

  // ---------------------------------------------------------------------------
  // Collision latch
  // ---------------------------------------------------------------------------
`ifdef SPRITE_COLLISION_EN
  logic [N_SPRITES-1:0] latch_q, latch_d;
  logic [N_SPRITES-1:0] collided_q, collided_d;
  logic                 multi_hit;

  // More than one bit set <=> clearing the lowest set bit leaves something.
  assign multi_hit = |(drawing & (drawing - 1'b1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      latch_q    <= '0;
      collided_q <= '0;
    end else begin
      latch_q    <= latch_d;
      collided_q <= collided_d;
    end
  end

  always_comb begin
    latch_d    = latch_q;
    collided_d = collided_q;
    if (state_q == S_IDLE && trigger) begin
      // Paused or not, the frame boundary publishes and restarts the latch.
      collided_d = latch_q;
      latch_d    = '0;
    end else if (state_q != S_UPDATE && multi_hit) begin
      latch_d = latch_q | drawing;
    end
  end

  assign collided = collided_q;
  assign flip     = collided_q[idx_q];
`else
  logic unused_drawing;
  assign unused_drawing = ^drawing;
  assign collided       = '0;
  assign flip           = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Slot datapath: one shared stepper, muxed by the slot index.
  // ---------------------------------------------------------------------------
  assign dx_eff = dx_neg_q[idx_q] ^ flip;
  assign dy_eff = dy_neg_q[idx_q] ^ flip;
  assign x_step = step_axis(x_q[idx_q], dx_eff, X_LIM);
  assign y_step = step_axis(y_q[idx_q], dy_eff, Y_LIM);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        x_q[i] <= rst_x[i];
        y_q[i] <= rst_y[i];
      end
      dx_neg_q <= rst_dx_neg;
      dy_neg_q <= '0;
    end else if (upd_en) begin
      x_q[idx_q]      <= x_step[9:0];
      y_q[idx_q]      <= y_step[9:0];
      dx_neg_q[idx_q] <= x_step[10];
      dy_neg_q[idx_q] <= y_step[10];
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sprite_motion_ctrl
//
// Directed bench for sprite_motion_ctrl with default parameters
// (4 slots, 640x480, 32x32 sprites, STEP=2). Expected positions are
// hand-computed constants. Honours SPRITE_COLLISION_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_sprite_motion_ctrl;

  logic        clk;
  logic        reset;
  logic        vsync;
  logic        pause;
  logic [3:0]  drawing;
  logic [39:0] sprite_x;
  logic [39:0] sprite_y;
  logic        busy;
  logic [15:0] frame_count;
  logic [3:0]  collided;

  int n_assert = 0;
  int n_fail   = 0;

  sprite_motion_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .vsync       (vsync),
    .pause       (pause),
    .drawing     (drawing),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .busy        (busy),
    .frame_count (frame_count),
    .collided    (collided)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] sx(input int i);
    return sprite_x[10*i +: 10];
  endfunction

  function automatic logic [9:0] sy(input int i);
    return sprite_y[10*i +: 10];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-14s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One vsync period: 8 cycles high, 6 low. Returns the number of sampled
  // cycles with busy high.
  task automatic frame(output int bc);
    bc = 0;
    vsync = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (busy) bc++;
    end
    vsync = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (busy) bc++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    int bc;
    int bc_total;
    reset   = 1'b0;
    vsync   = 1'b0;
    pause   = 1'b0;
    drawing = 4'b0000;
    do_reset();

    // Reset state
    check("rst_s0x", sx(0), 64);   check("rst_s0y", sy(0), 64);
    check("rst_s1x", sx(1), 192);  check("rst_s1y", sy(1), 128);
    check("rst_s2x", sx(2), 320);  check("rst_s2y", sy(2), 192);
    check("rst_s3x", sx(3), 448);  check("rst_s3y", sy(3), 256);
    check("rst_busy", busy, 0);
    check("rst_fc", frame_count, 0);
    check("rst_coll", collided, 0);

    // First frame
    frame(bc);
    check("f1_busy_len", bc, 5);
    check("f1_fc", frame_count, 1);
    check("f1_s0x", sx(0), 66);   check("f1_s0y", sy(0), 66);
    check("f1_s1x", sx(1), 190);  check("f1_s1y", sy(1), 130);
    check("f1_s2x", sx(2), 322);  check("f1_s2y", sy(2), 194);
    check("f1_s3x", sx(3), 446);  check("f1_s3y", sy(3), 258);

    // Pause across three vsync edges
    pause = 1'b1;
    bc_total = 0;
    for (int f = 0; f < 3; f++) begin
      frame(bc);
      bc_total += bc;
    end
    pause = 1'b0;
    check("pause_busy", bc_total, 0);
    check("pause_fc", frame_count, 1);
    check("pause_s0x", sx(0), 66);
    check("pause_s1y", sy(1), 130);
    check("pause_s3x", sx(3), 446);

    // Reset pulse during the second UPDATE cycle
    vsync = 1'b1;
    tick();                 // trigger edge: enter UPDATE
    tick();                 // slot 0 written, now in 2nd UPDATE cycle
    check("mid_busy", busy, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    vsync = 1'b0;
    check("mr_s0x", sx(0), 64);   check("mr_s0y", sy(0), 64);
    check("mr_s1x", sx(1), 192);  check("mr_s1y", sy(1), 128);
    check("mr_busy", busy, 0);
    check("mr_fc", frame_count, 0);
    tick();
    tick();
    frame(bc);
    check("mr_f1_s0x", sx(0), 66);  check("mr_f1_s0y", sy(0), 66);
    check("mr_f1_s1x", sx(1), 190); check("mr_f1_s1y", sy(1), 130);
    check("mr_f1_fc", frame_count, 1);

    // Long run through the edge bounces (k = frames completed)
    for (int k = 2; k <= 274; k++) begin
      frame(bc);
      case (k)
        95:  check("s1x_k95", sx(1), 2);
        96:  check("s1x_k96", sx(1), 0);
        97:  check("s1x_k97", sx(1), 0);
        98:  check("s1x_k98", sx(1), 2);
        192: check("s0y_k192", sy(0), 448);
        193: check("s0y_k193", sy(0), 448);
        194: check("s0y_k194", sy(0), 446);
        271: check("s0x_k271", sx(0), 606);
        272: check("s0x_k272", sx(0), 608);
        273: check("s0x_k273", sx(0), 608);
        274: begin
          check("s0x_k274", sx(0), 606);
          check("fc_k274", frame_count, 274);
        end
        default: ;
      endcase
    end

    // Collision pulse: slots 0 and 1 overlap for one cycle
    do_reset();
    frame(bc);
    drawing = 4'b0011;
    tick();
    drawing = 4'b0000;
    tick();
    frame(bc);
`ifdef SPRITE_COLLISION_EN
    check("col_flags", collided, 4'b0011);
    check("col_s0x", sx(0), 64);   check("col_s0y", sy(0), 64);
    check("col_s1x", sx(1), 192);  check("col_s1y", sy(1), 128);
    frame(bc);
    check("col_clear", collided, 0);
    check("col2_s0x", sx(0), 62);  check("col2_s0y", sy(0), 62);
    check("col2_s1x", sx(1), 194); check("col2_s1y", sy(1), 126);
`else
    check("col_flags", collided, 0);
    check("col_s0x", sx(0), 68);   check("col_s0y", sy(0), 68);
    check("col_s1x", sx(1), 188);  check("col_s1y", sy(1), 132);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
